// File: rtl/pctrl_gen.sv
`default_nettype none
// pctrl_gen: oversampled serial packet decoder driving a per-opcode execute window.
// Rev 1.0
module pctrl_gen #(
  parameter int ADDR_W      = 8,
  parameter int OP_W        = 3,
  parameter int BIT_CYCLES  = 4,
  parameter int EXEC_SHORT  = 31,
  parameter int EXEC_LONG   = 127,
  parameter logic [(1<<OP_W)-1:0] LONG_MASK  = 'h0C,
  parameter logic [(1<<OP_W)-1:0] PULSE_MASK = 'h60,
  parameter int SKIP_CYCLES = 200,
  parameter int BCAST_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rx,
  output logic [OP_W-1:0]   opcode,
  output logic              busy,
  output logic              err,
  output logic              bcast
);

  localparam int N    = ADDR_W + OP_W;
  localparam int MAX1 = (EXEC_LONG > SKIP_CYCLES) ? EXEC_LONG : SKIP_CYCLES;
  localparam int MAXC = (MAX1 > BIT_CYCLES) ? MAX1 : BIT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BW   = $clog2(N + 1);

  localparam logic [OP_W-1:0] NO_OP   = '1;
  localparam logic [CW-1:0]   C_HALF  = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0]   C_BIT   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0]   C_SHORT = CW'(EXEC_SHORT);
  localparam logic [CW-1:0]   C_LONG  = CW'(EXEC_LONG);
  localparam logic [CW-1:0]   C_SKIP  = CW'(SKIP_CYCLES);
  localparam logic [BW-1:0]   C_LAST  = BW'(N - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_EXECUTE = 3'd5;
  localparam logic [2:0] S_SKIP    = 3'd6;

  logic [2:0]      state;
  logic            sync1, rxs;
  logic            armed;
  logic [N-1:0]    shifter;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bitcnt;
  logic            par_bit, stop_bit, decide;
  logic [OP_W-1:0] exec_op;

  logic [ADDR_W-1:0] field;
  logic [OP_W-1:0]   rx_op;
  logic              is_bcast, is_match, par_ok;

  assign field    = shifter[ADDR_W-1:0];
  assign rx_op    = shifter[N-1:ADDR_W];
  assign is_bcast = (BCAST_EN != 0) && (&field);
  assign is_match = (field == address) || is_bcast;
  assign par_ok   = ~(^{shifter, par_bit});
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      shifter  <= '0;
      cnt      <= '0;
      bitcnt   <= '0;
      par_bit  <= 1'b0;
      stop_bit <= 1'b0;
      decide   <= 1'b0;
      exec_op  <= NO_OP;
      opcode   <= NO_OP;
      err      <= 1'b0;
      bcast    <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rxs) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= S_START;
            cnt   <= C_HALF;
          end
        end
        S_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxs) begin
            state <= S_IDLE;
          end else begin
            state  <= S_DATA;
            cnt    <= C_BIT;
            bitcnt <= '0;
          end
        end
        S_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shifter <= {rxs, shifter[N-1:1]};
            cnt     <= C_BIT;
            if (bitcnt == C_LAST) state <= S_PARITY;
            else                  bitcnt <= bitcnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            par_bit <= rxs;
            cnt     <= C_BIT;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          // Stop bit is sampled first; the decision lands one edge later.
          if (decide) begin
            decide <= 1'b0;
            if (!stop_bit || !par_ok) begin
              err   <= 1'b1;
              armed <= 1'b0;
              state <= S_IDLE;
            end else if (is_match) begin
              opcode  <= rx_op;
              exec_op <= rx_op;
              bcast   <= is_bcast;
              cnt     <= LONG_MASK[rx_op] ? C_LONG : C_SHORT;
              state   <= S_EXECUTE;
            end else begin
              cnt   <= C_SKIP;
              state <= S_SKIP;
            end
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            stop_bit <= rxs;
            decide   <= 1'b1;
          end
        end
        S_EXECUTE: begin
          if (cnt == '0) begin
            opcode <= NO_OP;
            bcast  <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (PULSE_MASK[exec_op]) opcode <= NO_OP;
          end
        end
        S_SKIP: begin
          if (cnt == '0) begin
            armed <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pctrl_gen.sv
`default_nettype none
// tb_pctrl_gen: directed frames with a busy-episode scoreboard for pctrl_gen.
module tb_pctrl_gen;

  localparam int BC = 4;
  localparam logic [2:0] NO_OP = 3'b111;

  typedef struct {
    int rise;
    int fall;
    int op;
    int opc;
    int bc;
    int errc;
  } ep_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] address = 8'h5A;
  logic [2:0] opcode, nb_opcode;
  logic       busy, err, bcast, nb_busy, nb_err, nb_bcast;

  int  cyc = 0;
  int  n_pass = 0;
  int  n_total = 0;
  ep_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pctrl_gen u_dut (
    .clk(clk), .rst(rst), .address(address), .rx(rx),
    .opcode(opcode), .busy(busy), .err(err), .bcast(bcast)
  );

  pctrl_gen #(.BCAST_EN(0)) u_nb (
    .clk(clk), .rst(rst), .address(address), .rx(rx),
    .opcode(nb_opcode), .busy(nb_busy), .err(nb_err), .bcast(nb_bcast)
  );

  task automatic check(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  // Monitor: every busy episode is one transaction, compared on its falling edge.
  logic in_ep = 1'b0;
  int   m_rise, m_op, m_opc, m_bc, m_err;
  always @(negedge clk) begin
    ep_t e;
    if (busy) begin
      if (!in_ep) begin
        in_ep = 1'b1; m_rise = cyc; m_op = int'(NO_OP); m_opc = 0; m_bc = 0; m_err = 0;
      end
      if (opcode != NO_OP) begin
        if (m_opc == 0) m_op = int'(opcode);
        m_opc++;
      end
      if (bcast) m_bc++;
      if (err) m_err++;
    end else if (in_ep) begin
      in_ep = 1'b0;
      if (err) m_err++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_episode: got busy %0d..%0d expected none", m_rise, cyc);
      end else begin
        e = exp_q.pop_front();
        check("busy_rise", m_rise, e.rise);
        check("busy_fall", cyc, e.fall);
        check("opcode_value", m_op, e.op);
        check("opcode_cycles", m_opc, e.opc);
        check("bcast_cycles", m_bc, e.bc);
        check("err_cycles", m_err, e.errc);
      end
    end else if (err) begin
      n_total++;
      $display("FAIL stray_err: got err=1 at cycle %0d expected 0", cyc);
    end
  end

  function automatic logic [13:0] mk(input logic [7:0] a, input logic [2:0] op,
                                     input logic flip, input logic stopb);
    logic par;
    par = (^{op, a}) ^ flip;
    return {stopb, par, op, a, 1'b0};
  endfunction

  task automatic push(input int t0, input int rise, input int fall, input int op,
                      input int opc, input int bc, input int errc);
    ep_t e;
    e.rise = t0 + rise; e.fall = t0 + fall; e.op = op;
    e.opc = opc; e.bc = bc; e.errc = errc;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [13:0] f, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      rx = f[i / BC];
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    rst = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_opcode", int'(opcode), 7);
    check("reset_busy", int'(busy), 0);
    check("reset_err", int'(err), 0);
    check("reset_bcast", int'(bcast), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Pulse opcode 5, short window: 32 cycles busy after the decision edge.
    t0 = cyc + 1; push(t0, 2, 89, 5, 1, 0, 0);
    send(mk(8'h5A, 3'd5, 1'b0, 1'b1), 56); rx = 1'b1;
    drain();

    // Long opcode 2: held 128 cycles.
    t0 = cyc + 1; push(t0, 2, 185, 2, 128, 0, 0);
    send(mk(8'h5A, 3'd2, 1'b0, 1'b1), 56); rx = 1'b1;
    drain();

    // Broadcast op 0; the BCAST_EN=0 instance skips the same frame instead.
    t0 = cyc + 1; push(t0, 2, 89, 0, 32, 32, 0);
    send(mk(8'hFF, 3'd0, 1'b0, 1'b1), 56); rx = 1'b1;
    while (cyc < t0 + 100) @(negedge clk);
    check("nb_busy_in_skip", int'(nb_busy), 1);
    check("nb_opcode_in_skip", int'(nb_opcode), 7);
    check("nb_bcast_in_skip", int'(nb_bcast), 0);
    while (cyc < t0 + 257) @(negedge clk);
    check("nb_busy_last_skip", int'(nb_busy), 1);
    @(negedge clk);
    check("nb_busy_after_skip", int'(nb_busy), 0);
    @(posedge clk); #1;
    drain();

    // Address mismatch, then a valid frame during SKIP that must be ignored.
    t0 = cyc + 1; push(t0, 2, 258, 7, 0, 0, 0);
    send(mk(8'h33, 3'd5, 1'b0, 1'b1), 56);
    send(mk(8'h5A, 3'd4, 1'b0, 1'b1), 56); rx = 1'b1;
    drain();

    // Flipped parity.
    t0 = cyc + 1; push(t0, 2, 57, 7, 0, 0, 1);
    send(mk(8'h5A, 3'd1, 1'b1, 1'b1), 56); rx = 1'b1;
    drain();

    // Stop bit 0 with the line held low afterwards: no new start until it rises.
    t0 = cyc + 1; push(t0, 2, 57, 7, 0, 0, 1);
    send(mk(8'h5A, 3'd3, 1'b0, 1'b0), 56);
    repeat (20) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    t0 = cyc + 1; push(t0, 2, 89, 4, 32, 0, 0);
    send(mk(8'h5A, 3'd4, 1'b0, 1'b1), 56); rx = 1'b1;
    drain();

    // One-cycle low glitch: START then back to IDLE.
    t0 = cyc + 1; push(t0, 2, 4, 7, 0, 0, 0);
    rx = 1'b0;
    @(posedge clk); #1;
    rx = 1'b1;
    drain();

    // Reset mid-frame, then a clean frame.
    t0 = cyc + 1; push(t0, 2, 30, 7, 0, 0, 0);
    send(mk(8'h5A, 3'd5, 1'b0, 1'b1), 30);
    rst = 1'b1; rx = 1'b1;
    @(posedge clk); #1;
    check("midrst_opcode", int'(opcode), 7);
    check("midrst_busy", int'(busy), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_bcast", int'(bcast), 0);
    rst = 1'b0;
    drain();
    t0 = cyc + 1; push(t0, 2, 89, 6, 1, 0, 0);
    send(mk(8'h5A, 3'd6, 1'b0, 1'b1), 56); rx = 1'b1;
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
